// File: rtl/hs_arith_pkg.sv
// hs_arith_pkg: shared types and helpers for the binary/Gray converter pipeline
//   cvt_mode_e      per-beat conversion direction
//   gray_slice_bits bits resolved per pipeline stage, ceil(width/stages)
package hs_arith_pkg;
  typedef enum logic {CVT_BIN2GRAY = 1'b0, CVT_GRAY2BIN = 1'b1} cvt_mode_e;
  function automatic int gray_slice_bits(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction
endpackage

// File: rtl/hs_arith_gray_pipe_stage.sv
// hs_arith_gray_pipe_stage: one register slice of the binary/Gray pipeline
//   clk, rst         clock, async active-high reset (clears v only)
//   v_i, adv_i       incoming beat valid, load enable for this slice
//   mode_i/acc_i/par_i/tag_i  beat fields from the previous slice (or the input port)
//   v_o/mode_o/acc_o/par_o/tag_o  registered fields of this slice
//   HI, LO           bit range resolved here for GRAY2BIN; HI < LO means a plain register slice
//   FIRST            slice 0: computes BIN2GRAY and uses a zero carry-in
module hs_arith_gray_pipe_stage
  import hs_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int HI    = 7,
  parameter int LO    = 0,
  parameter bit FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  input  logic             adv_i,
  input  cvt_mode_e        mode_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic             par_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             v_o,
  output cvt_mode_e        mode_o,
  output logic [WIDTH-1:0] acc_o,
  output logic             par_o,
  output logic [TAG_W-1:0] tag_o
);
  logic             v_q;
  cvt_mode_e        mode_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             par_q, par_d;
  logic [TAG_W-1:0] tag_q;
  // par_d walks down the slice as the running prefix XOR; its final value is the
  // binary bit at LO, which is the carry-in for the next slice
  always_comb begin
    acc_d = acc_i;
    par_d = FIRST ? 1'b0 : par_i;
    if (mode_i == CVT_BIN2GRAY) acc_d = FIRST ? acc_i ^ (acc_i >> 1) : acc_i;
    else
      for (int i = WIDTH - 1; i >= 0; i--)
        if (i <= HI && i >= LO) begin
          par_d    = par_d ^ acc_i[i];
          acc_d[i] = par_d;
        end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) v_q <= 1'b0;
    else if (adv_i) v_q <= v_i;
  always_ff @(posedge clk)
    if (adv_i) begin
      mode_q <= mode_i;
      acc_q  <= acc_d;
      par_q  <= par_d;
      tag_q  <= tag_i;
    end
  assign v_o    = v_q;
  assign mode_o = mode_q;
  assign acc_o  = acc_q;
  assign par_o  = par_q;
  assign tag_o  = tag_q;
endmodule

// File: rtl/hs_arith_binary_gray_cvt_pipe.sv
// hs_arith_binary_gray_cvt_pipe: streaming binary<->Gray converter, STAGES-deep, valid/ready both sides
//   clk, rst, flush                  clock, async active-high reset, sync pipeline clear
//   in_valid/in_ready/in_mode/in_data/in_tag      input beat (mode 0 = BIN2GRAY, 1 = GRAY2BIN)
//   out_valid/out_ready/out_mode/out_data/out_tag output beat from the last slice
//   busy                             any slice holds a beat
module hs_arith_binary_gray_cvt_pipe
  import hs_arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int SL = gray_slice_bits(WIDTH, STAGES);
  if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > 8 || STAGES > WIDTH || TAG_W < 1 || TAG_W > 16)
    begin : g_bad_params
    $fatal(1, "hs_arith_binary_gray_cvt_pipe: illegal WIDTH/STAGES/TAG_W");
  end
  logic [STAGES-1:0] v, ld;
  cvt_mode_e         mode [STAGES];
  logic [WIDTH-1:0]  acc  [STAGES];
  logic              par  [STAGES];
  logic [TAG_W-1:0]  tag  [STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int HI = WIDTH - 1 - s * SL;
    localparam int LO = (WIDTH - (s + 1) * SL) > 0 ? WIDTH - (s + 1) * SL : 0;
    logic             vi, pi;
    cvt_mode_e        mi;
    logic [WIDTH-1:0] ai;
    logic [TAG_W-1:0] ti;
    if (s == 0) begin : g_src
      assign vi = in_valid & ~flush;
      assign mi = cvt_mode_e'(in_mode);
      assign ai = in_data;
      assign pi = 1'b0;
      assign ti = in_tag;
    end else begin : g_src
      assign vi = v[s-1] & ~flush;
      assign mi = mode[s-1];
      assign ai = acc[s-1];
      assign pi = par[s-1];
      assign ti = tag[s-1];
    end
    // a slice loads when empty or when its content moves on, so bubbles collapse
    if (s == STAGES - 1) begin : g_ld
      assign ld[s] = ~v[s] | out_ready;
    end else begin : g_ld
      assign ld[s] = ~v[s] | ld[s+1];
    end
    // flush forces every slice to load an invalid beat
    hs_arith_gray_pipe_stage #(
      .WIDTH(WIDTH), .TAG_W(TAG_W), .HI(HI), .LO(LO), .FIRST(s == 0)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .v_i   (vi),
      .adv_i (ld[s] | flush),
      .mode_i(mi),
      .acc_i (ai),
      .par_i (pi),
      .tag_i (ti),
      .v_o   (v[s]),
      .mode_o(mode[s]),
      .acc_o (acc[s]),
      .par_o (par[s]),
      .tag_o (tag[s])
    );
  end
  assign in_ready  = ld[0] & ~flush;
  assign out_valid = v[STAGES-1];
  assign out_mode  = mode[STAGES-1];
  assign out_data  = acc[STAGES-1];
  assign out_tag   = tag[STAGES-1];
  assign busy      = |v;
endmodule
